onchip_capture_ram: RTL and testbench
=====================================

Name: onchip_capture_ram

Overview:
- Parametrised successor to the team's single-port Avalon-MM on-chip RAM.
- Port s1 is an Avalon-MM slave for the Nios: read/write, byteenable, configurable read latency, readdatavalid.
- Port s2 is an Avalon-ST sink: ADS1299 sample words are written sequentially into the same array as a ring or one-shot capture buffer.
- Sits between the ADC front-end and the processor data bus.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- ADDR_W, 15, word address width; DEPTH = 2**ADDR_W.
- READ_LATENCY, 1, s1 read latency in cycles; legal values 1 or 2 (2 adds an output register).
- WRAP_MODE, 1, 1 = ring buffer overwrites oldest data; 0 = stop when full.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clken  in  1  global clock enable; 0 freezes all state
- s1_address  in  ADDR_W  word address
- s1_chipselect  in  1  slave select
- s1_read  in  1  read request
- s1_write  in  1  write request
- s1_byteenable  in  DATA_W/8  byte lanes for writes
- s1_writedata  in  DATA_W  write data
- s1_readdata  out  DATA_W  read data
- s1_readdatavalid  out  1  read data qualifier
- snk_valid  in  1  sample valid
- snk_data  in  DATA_W  sample word
- snk_ready  out  1  sink ready
- cap_arm  in  1  one-cycle pulse: clear pointer and flags, start capture
- cap_stop  in  1  one-cycle pulse: stop capture
- cap_wr_ptr  out  ADDR_W  next address s2 will write
- cap_active  out  1  capture running
- cap_full  out  1  buffer filled at least once (sticky until arm)

Behaviour:
- Reset values: s1_readdata=0, s1_readdatavalid=0, snk_ready=0, cap_wr_ptr=0, cap_active=0, cap_full=0, read pipeline cleared. RAM contents are undefined.
- clken=0: no state changes, no RAM writes, readdatavalid pipeline holds. Inputs presented while clken=0 are ignored.
- s1 write: accepted when chipselect&write. Only bytes with byteenable=1 are written. Zero wait states; no waitrequest.
- s1 read: accepted when chipselect&read&~write. Data and readdatavalid=1 appear exactly READ_LATENCY cycles later. One read per cycle, fully pipelined.
- s1 read of an address written the same cycle (by s1 or s2) returns old data.
- s2 write: occurs when snk_valid&snk_ready. Writes snk_data to cap_wr_ptr, then cap_wr_ptr increments modulo DEPTH.
- Capture state machine:
  - IDLE -> RUN on cap_arm: pointer=0, cap_full=0.
  - RUN -> IDLE on cap_stop.
  - On the write to address DEPTH-1: cap_full=1.
    - WRAP_MODE=1: stay in RUN; pointer wraps to 0.
    - WRAP_MODE=0: go to DONE; pointer wraps to 0.
  - DONE -> RUN only on cap_arm.
  - cap_active=1 only in RUN.
- snk_ready = cap_active (registered state). Samples arriving outside RUN are dropped.
- Simultaneous cap_arm and cap_stop: arm wins.
- cap_arm during RUN: restarts the capture. Pointer reset and flags clear take effect next cycle; a sample handshaken the same cycle is written to the old pointer.
- Same-address write collision between s1 and s2 in one cycle: s2 wins; the s1 write is discarded.
- reset_n asserted mid-operation: all control state returns to reset values immediately; in-flight reads are lost (no readdatavalid).

Optional Feature:
- Macro: CAPTURE_IRQ_EN.
- When defined: adds output cap_irq (1 bit), a level set on a half-full crossing (write to address DEPTH/2-1) and on a full crossing. Adds input irq_ack (1 bit); a pulse clears cap_irq. If set and clear occur in the same cycle, set wins.
- When not defined: neither port exists and no related logic is built.

Decomposition:
- Package onchip_capture_pkg:
  - capture state enum (IDLE, RUN, DONE)
  - READ_LATENCY legality check constants
  - byte-lane count function DATA_W/8
- Sub-module ram_tdp_core: true dual-port RAM with byte-enable on port A and full-word write on port B. Write-collision priority and the optional output register are handled in the parent.

Test Plan:
- Reset/latency: READ_LATENCY=2. s1 write 0xDEADBEEF to address 5, then read address 5 -> readdatavalid high exactly 2 cycles after the read, data 0xDEADBEEF. Back-to-back reads of addresses 5, 6 -> two consecutive valid cycles.
- Byteenable: write 0xFFFFFFFF to address 3, then write 0x12345678 with be=0b0101 -> read address 3 returns 0xFF34FF78.
- Ring wrap: ADDR_W=4, WRAP_MODE=1, arm, then 20 samples valued 0..19 -> cap_full set on the 16th sample; cap_wr_ptr=4; addresses 0..3 hold 16..19; cap_active stays 1.
- Stop-when-full: ADDR_W=4, WRAP_MODE=0, 20 samples -> snk_ready drops after the 16th; samples 16..19 are dropped; address 0 holds 0. cap_arm then restarts with cap_wr_ptr=0 and cap_full=0.
- Collision/clken: s1 and s2 both write address 7 in the same cycle -> read returns the s2 data. Pulse clken=0 for 3 cycles mid-read -> readdatavalid is delayed by 3 cycles with data intact.
- IRQ (CAPTURE_IRQ_EN defined): ADDR_W=4 -> cap_irq rises after the 8th sample; irq_ack clears it; it rises again after the 16th sample.

Source files
------------

// File: rtl/onchip_capture_pkg.sv
// Shared types and helpers for the onchip_capture_ram block: capture state codes,
// legal s1 read-latency range and byte-lane arithmetic.
package onchip_capture_pkg;

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t CAP_IDLE = 2'd0;
  localparam cap_state_t CAP_RUN  = 2'd1;
  localparam cap_state_t CAP_DONE = 2'd2;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit read_latency_legal(input int lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/ram_tdp_core.sv
// True dual-port RAM: port A reads and writes with byte enables, port B writes whole words.
// Reads return the contents from before any write landing in the same cycle.
module ram_tdp_core
  import onchip_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic                    a_we,
  input  logic [DATA_W/8-1:0]     a_be,
  input  logic [DATA_W-1:0]       a_wdata,
  output logic [DATA_W-1:0]       a_rdata,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic                    b_we,
  input  logic [DATA_W-1:0]       b_wdata
);

  localparam int BE_W = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      a_rdata <= mem[a_addr];
      for (int i = 0; i < BE_W; i++) begin
        if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
      if (b_we) mem[b_addr] <= b_wdata;
    end
  end

endmodule

// File: rtl/onchip_capture_ram.sv
// On-chip RAM shared by an Avalon-MM slave (s1) and an Avalon-ST capture sink (s2).
// Optional interrupt output cap_irq / irq_ack is built when CAPTURE_IRQ_EN is defined.
module onchip_capture_ram
  import onchip_capture_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1,
  parameter int WRAP_MODE    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic                snk_valid,
  input  logic [DATA_W-1:0]   snk_data,
  output logic                snk_ready,
  input  logic                cap_arm,
  input  logic                cap_stop,
  output logic [ADDR_W-1:0]   cap_wr_ptr,
  output logic                cap_active,
  output logic                cap_full
`ifdef CAPTURE_IRQ_EN
  ,
  output logic                cap_irq,
  input  logic                irq_ack
`endif
);

  // Out-of-range latencies fall back to the single-cycle path.
  localparam bit USE_OUT_REG = read_latency_legal(READ_LATENCY) &&
                               (READ_LATENCY == READ_LATENCY_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] HALF_ADDR = LAST_ADDR >> 1;

  cap_state_t        state;
  logic              s1_rd_req;
  logic              s1_wr_req;
  logic              s1_wr_en;
  logic              s2_wr;
  logic              rd_valid_q;
  logic [DATA_W-1:0] ram_q;

  assign s1_rd_req  = s1_chipselect & s1_read & ~s1_write;
  assign s1_wr_req  = s1_chipselect & s1_write;
  assign s2_wr      = snk_valid & snk_ready;
  // The capture stream owns an address both ports hit in the same cycle.
  assign s1_wr_en   = s1_wr_req & ~(s2_wr && (s1_address == cap_wr_ptr));
  assign snk_ready  = (state == CAP_RUN);
  assign cap_active = (state == CAP_RUN);

  ram_tdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en      (clken),
    .a_addr  (s1_address),
    .a_we    (s1_wr_en),
    .a_be    (s1_byteenable),
    .a_wdata (s1_writedata),
    .a_rdata (ram_q),
    .b_addr  (cap_wr_ptr),
    .b_we    (s2_wr),
    .b_wdata (snk_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_valid_q <= 1'b0;
    else if (clken) rd_valid_q <= s1_rd_req;
  end

  generate
    if (USE_OUT_REG) begin : g_out_reg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_readdata      <= '0;
          s1_readdatavalid <= 1'b0;
        end else if (clken) begin
          s1_readdatavalid <= rd_valid_q;
          if (rd_valid_q) s1_readdata <= ram_q;
        end
      end
    end else begin : g_no_out_reg
      assign s1_readdatavalid = rd_valid_q;
      assign s1_readdata      = rd_valid_q ? ram_q : '0;
    end
  endgenerate

  // Arm outranks everything; a sample taken alongside arm still lands at the old pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CAP_IDLE;
      cap_wr_ptr <= '0;
      cap_full   <= 1'b0;
    end else if (clken) begin
      if (cap_arm) begin
        state      <= CAP_RUN;
        cap_wr_ptr <= '0;
        cap_full   <= 1'b0;
      end else begin
        if (s2_wr) begin
          cap_wr_ptr <= cap_wr_ptr + 1'b1;
          if (cap_wr_ptr == LAST_ADDR) begin
            cap_full <= 1'b1;
            if (WRAP_MODE == 0) state <= CAP_DONE;
          end
        end
        if (cap_stop && (state == CAP_RUN)) state <= CAP_IDLE;
      end
    end
  end

`ifdef CAPTURE_IRQ_EN
  logic irq_set;

  assign irq_set = s2_wr && ((cap_wr_ptr == HALF_ADDR) || (cap_wr_ptr == LAST_ADDR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cap_irq <= 1'b0;
    else if (clken) begin
      if (irq_set)               cap_irq <= 1'b1;
      else if (irq_ack)          cap_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_capture_ram.sv
// Bench for onchip_capture_ram: two 16-word instances share one stimulus stream,
// A = READ_LATENCY 2 / ring buffer, B = READ_LATENCY 1 / stop-when-full.
module tb_onchip_capture_ram;

  logic        clk;
  logic        rst_n;
  logic        clken;
  logic [3:0]  s1_address;
  logic        s1_chipselect;
  logic        s1_read;
  logic        s1_write;
  logic [3:0]  s1_byteenable;
  logic [31:0] s1_writedata;
  logic        snk_valid;
  logic [31:0] snk_data;
  logic        cap_arm;
  logic        cap_stop;
  logic        irq_ack;

  logic [31:0] ra_rdata, rb_rdata;
  logic        ra_rvalid, rb_rvalid;
  logic        ra_ready, rb_ready;
  logic [3:0]  ra_ptr, rb_ptr;
  logic        ra_active, rb_active;
  logic        ra_full, rb_full;
  logic        ra_irq, rb_irq;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  onchip_capture_ram #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .WRAP_MODE(1)
  ) dut_a (
    .clk(clk), .reset_n(rst_n), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(ra_rdata), .s1_readdatavalid(ra_rvalid),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(ra_ready),
    .cap_arm(cap_arm), .cap_stop(cap_stop), .cap_wr_ptr(ra_ptr),
    .cap_active(ra_active), .cap_full(ra_full)
`ifdef CAPTURE_IRQ_EN
    , .cap_irq(ra_irq), .irq_ack(irq_ack)
`endif
  );

  onchip_capture_ram #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .WRAP_MODE(0)
  ) dut_b (
    .clk(clk), .reset_n(rst_n), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rb_rdata), .s1_readdatavalid(rb_rvalid),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(rb_ready),
    .cap_arm(cap_arm), .cap_stop(cap_stop), .cap_wr_ptr(rb_ptr),
    .cap_active(rb_active), .cap_full(rb_full)
`ifdef CAPTURE_IRQ_EN
    , .cap_irq(rb_irq), .irq_ack(irq_ack)
`endif
  );

`ifndef CAPTURE_IRQ_EN
  assign ra_irq = 1'b0;
  assign rb_irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic s1_write_word(input logic [3:0] addr, input logic [3:0] be,
                               input logic [31:0] data);
    s1_chipselect = 1'b1;
    s1_write      = 1'b1;
    s1_address    = addr;
    s1_byteenable = be;
    s1_writedata  = data;
    next_cycle();
    s1_chipselect = 1'b0;
    s1_write      = 1'b0;
  endtask

  // Issue one read and measure when each instance raises readdatavalid.
  task automatic read_check(input logic [3:0] addr, input logic [31:0] exp_a,
                            input logic [31:0] exp_b, input string name);
    int lat_a = 0;
    int lat_b = 0;
    logic [31:0] d_a = '0;
    logic [31:0] d_b = '0;
    s1_chipselect = 1'b1;
    s1_read       = 1'b1;
    s1_write      = 1'b0;
    s1_address    = addr;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 1) begin
        s1_chipselect = 1'b0;
        s1_read       = 1'b0;
        snk_valid     = 1'b0;
      end
      if (ra_rvalid && lat_a == 0) begin lat_a = c; d_a = ra_rdata; end
      if (rb_rvalid && lat_b == 0) begin lat_b = c; d_b = rb_rdata; end
    end
    checkOutput({name, "_lat_a"}, lat_a, 2);
    checkOutput({name, "_lat_b"}, lat_b, 1);
    checkOutput({name, "_data_a"}, d_a, exp_a);
    checkOutput({name, "_data_b"}, d_b, exp_b);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    s1_write_word(v.addr, v.be, v.wdata);
    read_check(v.addr, v.exp, v.exp, $sformatf("vec%0d", idx));
  endtask

  task automatic pulse_arm();
    cap_arm = 1'b1;
    next_cycle();
    cap_arm = 1'b0;
  endtask

  task automatic send_samples(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      snk_valid = 1'b1;
      snk_data  = base + 32'(i);
      next_cycle();
    end
    snk_valid = 1'b0;
  endtask

  initial begin
    logic        va [1:5];
    logic        vb [1:5];
    logic [31:0] da [1:5];
    logic [31:0] db [1:5];
    int          lat_a;
    int          lat_b;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        seen_valid;

    vecs[0] = '{addr: 4'd5, be: 4'hF, wdata: 32'hDEADBEEF, exp: 32'hDEADBEEF};
    vecs[1] = '{addr: 4'd6, be: 4'hF, wdata: 32'hCAFEF00D, exp: 32'hCAFEF00D};
    vecs[2] = '{addr: 4'd3, be: 4'hF, wdata: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};
    vecs[3] = '{addr: 4'd3, be: 4'h5, wdata: 32'h12345678, exp: 32'hFF34FF78};
    vecs[4] = '{addr: 4'd3, be: 4'h0, wdata: 32'h00000000, exp: 32'hFF34FF78};
    vecs[5] = '{addr: 4'd3, be: 4'hA, wdata: 32'hAABBCCDD, exp: 32'hAA34CC78};
    vecs[6] = '{addr: 4'd9, be: 4'hF, wdata: 32'h00000000, exp: 32'h00000000};
    vecs[7] = '{addr: 4'd9, be: 4'h8, wdata: 32'h11223344, exp: 32'h11000000};
    vecs[8] = '{addr: 4'd9, be: 4'h2, wdata: 32'h55667788, exp: 32'h11007700};

    rst_n = 1'b0; clken = 1'b1;
    s1_address = '0; s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s1_byteenable = '0; s1_writedata = '0;
    snk_valid = 1'b0; snk_data = '0; cap_arm = 1'b0; cap_stop = 1'b0; irq_ack = 1'b0;
    repeat (3) next_cycle();

    checkOutput("rst_rdata_a", ra_rdata, 32'h0);
    checkOutput("rst_rdata_b", rb_rdata, 32'h0);
    checkOutput("rst_valid_a", ra_rvalid, 0);
    checkOutput("rst_valid_b", rb_rvalid, 0);
    checkOutput("rst_ready_a", ra_ready, 0);
    checkOutput("rst_ptr_b", rb_ptr, 0);
    checkOutput("rst_active_a", ra_active, 0);
    checkOutput("rst_full_b", rb_full, 0);
    checkOutput("rst_irq_a", ra_irq, 0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Back-to-back reads of 5 and 6.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 4'd5;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 1) s1_address = 4'd6;
      if (c == 2) begin s1_chipselect = 1'b0; s1_read = 1'b0; end
      va[c] = ra_rvalid; da[c] = ra_rdata;
      vb[c] = rb_rvalid; db[c] = rb_rdata;
    end
    checkOutput("b2b_va1", va[1], 0);
    checkOutput("b2b_va2", va[2], 1);
    checkOutput("b2b_va3", va[3], 1);
    checkOutput("b2b_va4", va[4], 0);
    checkOutput("b2b_da2", da[2], 32'hDEADBEEF);
    checkOutput("b2b_da3", da[3], 32'hCAFEF00D);
    checkOutput("b2b_vb1", vb[1], 1);
    checkOutput("b2b_vb2", vb[2], 1);
    checkOutput("b2b_vb3", vb[3], 0);
    checkOutput("b2b_db1", db[1], 32'hDEADBEEF);
    checkOutput("b2b_db2", db[2], 32'hCAFEF00D);

    // Ring (A) versus stop-when-full (B) with 20 samples 0..19.
    pulse_arm();
    checkOutput("arm_active_a", ra_active, 1);
    checkOutput("arm_ready_b", rb_ready, 1);
    checkOutput("arm_ptr_a", ra_ptr, 0);
    for (int i = 0; i < 20; i++) begin
      snk_valid = 1'b1;
      snk_data  = 32'(i);
      next_cycle();
      if (i == 14) begin
        checkOutput("s15_full_a", ra_full, 0);
        checkOutput("s15_full_b", rb_full, 0);
        checkOutput("s15_ptr_b", rb_ptr, 15);
      end
      if (i == 15) begin
        checkOutput("s16_full_a", ra_full, 1);
        checkOutput("s16_full_b", rb_full, 1);
        checkOutput("s16_ready_b", rb_ready, 0);
        checkOutput("s16_ptr_a", ra_ptr, 0);
      end
    end
    snk_valid = 1'b0;
    checkOutput("ring_ptr_a", ra_ptr, 4);
    checkOutput("ring_active_a", ra_active, 1);
    checkOutput("ring_full_a", ra_full, 1);
    checkOutput("stop_ptr_b", rb_ptr, 0);
    checkOutput("stop_active_b", rb_active, 0);
    checkOutput("stop_full_b", rb_full, 1);
    for (int a = 0; a < 4; a++)
      read_check(4'(a), 32'(16 + a), 32'(a), $sformatf("ring_addr%0d", a));
    read_check(4'd15, 32'd15, 32'd15, "ring_addr15");

    pulse_arm();
    checkOutput("rearm_ptr_b", rb_ptr, 0);
    checkOutput("rearm_full_b", rb_full, 0);
    checkOutput("rearm_active_b", rb_active, 1);
    checkOutput("rearm_full_a", ra_full, 0);

    // s1/s2 collision at address 7, then a non-colliding pair (s1 -> 12, s2 -> 8).
    send_samples(7, 32'h100);
    checkOutput("coll_ptr_a", ra_ptr, 7);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_byteenable = 4'hF;
    s1_address = 4'd7; s1_writedata = 32'hAAAAAAAA;
    snk_valid = 1'b1; snk_data = 32'h55555555;
    next_cycle();
    s1_address = 4'd12; s1_writedata = 32'h0C0C0C0C;
    snk_data = 32'h88888888;
    next_cycle();
    s1_chipselect = 1'b0; s1_write = 1'b0; snk_valid = 1'b0;
    read_check(4'd7, 32'h55555555, 32'h55555555, "coll_addr7");
    read_check(4'd12, 32'h0C0C0C0C, 32'h0C0C0C0C, "pair_addr12");
    read_check(4'd8, 32'h88888888, 32'h88888888, "pair_addr8");

    // Read of address 9 while s2 overwrites it returns the old sample.
    snk_valid = 1'b1; snk_data = 32'h99999999;
    read_check(4'd9, 32'd9, 32'd9, "rdold_addr9");
    read_check(4'd9, 32'h99999999, 32'h99999999, "rdnew_addr9");
    checkOutput("rdold_ptr_b", rb_ptr, 10);

    // clken low for 3 cycles right after a read is accepted; all inputs ignored meanwhile.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 4'd12;
    lat_a = 0; lat_b = 0; d_a = '0; d_b = '0;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (c == 1) begin
        clken = 1'b0; s1_read = 1'b0; s1_write = 1'b1; s1_byteenable = 4'hF;
        s1_writedata = 32'hBAD0BAD0; snk_valid = 1'b1; snk_data = 32'hEEEEEEEE;
        cap_stop = 1'b1;
      end
      if (c == 4) begin
        clken = 1'b1; s1_chipselect = 1'b0; s1_write = 1'b0;
        snk_valid = 1'b0; cap_stop = 1'b0;
      end
      if (ra_rvalid && lat_a == 0) begin lat_a = c; d_a = ra_rdata; end
      if (rb_rvalid && lat_b == 0) begin lat_b = c; d_b = rb_rdata; end
    end
    checkOutput("clken_lat_a", lat_a, 5);
    checkOutput("clken_data_a", d_a, 32'h0C0C0C0C);
    checkOutput("clken_lat_b", lat_b, 1);
    checkOutput("clken_data_b", d_b, 32'h0C0C0C0C);
    checkOutput("clken_ptr_a", ra_ptr, 10);
    checkOutput("clken_active_b", rb_active, 1);
    read_check(4'd12, 32'h0C0C0C0C, 32'h0C0C0C0C, "clken_addr12");

    // Stop, samples dropped while idle, then simultaneous arm+stop.
    cap_stop = 1'b1;
    next_cycle();
    cap_stop = 1'b0;
    checkOutput("stop_active_a", ra_active, 0);
    checkOutput("stop_ready_b", rb_ready, 0);
    send_samples(2, 32'h77);
    checkOutput("idle_ptr_a", ra_ptr, 10);
    cap_arm = 1'b1; cap_stop = 1'b1;
    next_cycle();
    cap_arm = 1'b0; cap_stop = 1'b0;
    checkOutput("armstop_active_a", ra_active, 1);
    checkOutput("armstop_ptr_b", rb_ptr, 0);
    send_samples(3, 32'h300);
    checkOutput("pre_rst_ptr_a", ra_ptr, 3);

    // Reset asserted with a read in flight.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 4'd0;
    next_cycle();
    s1_chipselect = 1'b0; s1_read = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid_b", rb_rvalid, 0);
    checkOutput("midrst_ptr_a", ra_ptr, 0);
    checkOutput("midrst_active_b", rb_active, 0);
    checkOutput("midrst_ready_a", ra_ready, 0);
    seen_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 2) rst_n = 1'b1;
      if (ra_rvalid || rb_rvalid) seen_valid = 1'b1;
    end
    checkOutput("midrst_lost_read", seen_valid, 0);

`ifdef CAPTURE_IRQ_EN
    checkOutput("irq_rst_b", rb_irq, 0);
    pulse_arm();
    for (int i = 0; i < 8; i++) begin
      snk_valid = 1'b1; snk_data = 32'(i);
      next_cycle();
      if (i == 6) checkOutput("irq_s7_a", ra_irq, 0);
    end
    snk_valid = 1'b0;
    checkOutput("irq_half_a", ra_irq, 1);
    checkOutput("irq_half_b", rb_irq, 1);
    irq_ack = 1'b1;
    next_cycle();
    irq_ack = 1'b0;
    checkOutput("irq_ack_a", ra_irq, 0);
    checkOutput("irq_ack_b", rb_irq, 0);
    for (int i = 8; i < 16; i++) begin
      snk_valid = 1'b1; snk_data = 32'(i);
      next_cycle();
      if (i == 14) checkOutput("irq_s15_b", rb_irq, 0);
    end
    snk_valid = 1'b0;
    checkOutput("irq_full_a", ra_irq, 1);
    checkOutput("irq_full_b", rb_irq, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
